// File: rtl/line_interp_step.sv
// Linear interpolator step engine: runs one XY segment and emits axis step pulses.
// Optional LINE_FEED_DIV_EN adds a feed_div input that slows WORK ticks to one per feed_div+1 cycles.
module line_interp_step #(
  parameter int W = 16
) (
  input  logic         pulse_clk,
  input  logic         sys_rst_l,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] xe_abs,
  input  logic [W-1:0] ye_abs,
  input  logic         x_sign,
  input  logic         y_sign,
`ifdef LINE_FEED_DIV_EN
  input  logic [15:0]  feed_div,
`endif
  output logic         x_step,
  output logic         y_step,
  output logic         x_dir,
  output logic         y_dir,
  output logic         busy,
  output logic         done,
  output logic [W:0]   steps_left
);

  typedef enum logic [1:0] {IDLE, INIT, WORK, OVER} state_t;

  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [W-1:0]       xe_q, ye_q;
  logic signed [W+1:0] f_q;
  logic [W:0]         sum;
  logic               tick;
  logic               take_x;
  logic               step_now;

`ifdef LINE_FEED_DIV_EN
  logic [15:0] div_q, div_cnt;
  assign tick = (div_cnt == 16'd0);
`else
  assign tick = 1'b1;
`endif

  assign sum = {1'b0, xe_q} + {1'b0, ye_q};

  // X is preferred while the deviation is non-negative; a zero axis forces the other one.
  assign take_x   = (!f_q[W+1] && (xe_q != '0)) || (ye_q == '0);
  assign step_now = (state == WORK) && tick && !abort;

  // Step and done are decoded from state so the first step lands two cycles after start.
  assign x_step = step_now && take_x;
  assign y_step = step_now && !take_x;
  assign busy   = (state != IDLE);
  assign done   = (state == OVER) && !abort;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = INIT;
        INIT:    state_nxt = (sum == '0) ? OVER : WORK;
        WORK:    if (tick && (steps_left == ONE)) state_nxt = OVER;
        OVER:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state      <= IDLE;
      xe_q       <= '0;
      ye_q       <= '0;
      x_dir      <= 1'b0;
      y_dir      <= 1'b0;
      f_q        <= '0;
      steps_left <= '0;
`ifdef LINE_FEED_DIV_EN
      div_q      <= '0;
      div_cnt    <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            xe_q  <= xe_abs;
            ye_q  <= ye_abs;
            x_dir <= x_sign;
            y_dir <= y_sign;
`ifdef LINE_FEED_DIV_EN
            div_q <= feed_div;
`endif
          end
        end
        INIT: begin
          f_q        <= '0;
          steps_left <= sum;
`ifdef LINE_FEED_DIV_EN
          div_cnt    <= '0;
`endif
        end
        WORK: begin
          if (step_now) begin
            if (take_x) f_q <= f_q - $signed({2'b00, ye_q});
            else        f_q <= f_q + $signed({2'b00, xe_q});
            steps_left <= steps_left - ONE;
`ifdef LINE_FEED_DIV_EN
            div_cnt    <= div_q;
          end else if (!tick) begin
            div_cnt    <= div_cnt - 16'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_interp_step.sv
// Self-checking bench for line_interp_step: scoreboard of expected step axes plus per-scenario checks.
// Handshake: start is a one-cycle request sampled on a rising edge; outputs are sampled on falling edges.
module tb_line_interp_step;
  localparam int W = 16;

  logic         pulse_clk = 1'b0;
  logic         sys_rst_l = 1'b0;
  logic         start     = 1'b0;
  logic         abort     = 1'b0;
  logic [W-1:0] xe_abs    = '0;
  logic [W-1:0] ye_abs    = '0;
  logic         x_sign    = 1'b0;
  logic         y_sign    = 1'b0;
`ifdef LINE_FEED_DIV_EN
  logic [15:0]  feed_div  = 16'd0;
`endif
  logic         x_step, y_step, x_dir, y_dir, busy, done;
  logic [W:0]   steps_left;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;

  logic [1:0] exp_q[$];
  int         pulse_cyc[$];
  bit         pulse_x[$];
  int         done_cnt = 0;
  int         done_cyc = -1;

  line_interp_step #(.W(W)) dut (
    .pulse_clk  (pulse_clk),
    .sys_rst_l  (sys_rst_l),
    .start      (start),
    .abort      (abort),
    .xe_abs     (xe_abs),
    .ye_abs     (ye_abs),
    .x_sign     (x_sign),
    .y_sign     (y_sign),
`ifdef LINE_FEED_DIV_EN
    .feed_div   (feed_div),
`endif
    .x_step     (x_step),
    .y_step     (y_step),
    .x_dir      (x_dir),
    .y_dir      (y_dir),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  // Clock / reset block
  always #5 pulse_clk = ~pulse_clk;
  always @(posedge pulse_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every step pulse pops one expected axis
  always @(negedge pulse_clk) begin
    logic [1:0] e;
    if (x_step && y_step) begin
      n_checks++;
      n_fail++;
      $display("FAIL both_steps cyc=%0d got x_step=1 y_step=1, required at most one", cyc);
    end
    if (x_step || y_step) begin
      pulse_cyc.push_back(cyc);
      pulse_x.push_back(x_step);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL step_unexpected cyc=%0d got {x,y}=%b, required no step", cyc, {x_step, y_step});
      end else begin
        e = exp_q.pop_front();
        if ({x_step, y_step} !== e) begin
          n_fail++;
          $display("FAIL step_axis cyc=%0d got {x,y}=%b, required %b", cyc, {x_step, y_step}, e);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Driver tasks
  task automatic push_model(input int xe, input int ye);
    int f = 0;
    for (int i = 0; i < xe + ye; i++) begin
      if ((f >= 0 && xe != 0) || ye == 0) begin
        exp_q.push_back(2'b10);
        f = f - ye;
      end else begin
        exp_q.push_back(2'b01);
        f = f + xe;
      end
    end
  endtask

  task automatic start_seg(input int xe, input int ye, input bit xs, input bit ys);
    @(posedge pulse_clk);
    #1;
    pulse_cyc.delete();
    pulse_x.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    xe_abs    = W'(xe);
    ye_abs    = W'(ye);
    x_sign    = xs;
    y_sign    = ys;
    start     = 1'b1;
    start_cyc = cyc;
    push_model(xe, ye);
    @(posedge pulse_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge pulse_clk);
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge pulse_clk);
    #1;
  endtask

  function automatic int count_x();
    int n = 0;
    foreach (pulse_x[i]) if (pulse_x[i]) n++;
    return n;
  endfunction

  // Scenario tasks
  task automatic test_reset();
    repeat (2) @(posedge pulse_clk);
    #1;
    n_checks++;
    if ({x_step, y_step, x_dir, y_dir, busy, done} !== 6'b0 || steps_left !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got flags=%b steps_left=%0d, required 0/0",
               {x_step, y_step, x_dir, y_dir, busy, done}, steps_left);
    end
    sys_rst_l = 1'b1;
    @(negedge pulse_clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_diagonal();
    bit to;
    logic [7:0] seq;
    start_seg(5, 3, 1'b0, 1'b1);
    @(negedge pulse_clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL diag_busy got %b, required 1", busy);
    end
    @(negedge pulse_clk);
    n_checks++;
    if (x_dir !== 1'b0 || y_dir !== 1'b1 || steps_left !== 17'd8) begin
      n_fail++;
      $display("FAIL diag_dir_steps got x_dir=%b y_dir=%b steps_left=%0d, required 0 1 8",
               x_dir, y_dir, steps_left);
    end
    wait_idle(40, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL diag_timeout got busy after 40 cycles, required idle");
    end
    n_checks++;
    if (pulse_x.size() != 8) begin
      n_fail++;
      $display("FAIL diag_count got %0d pulses, required 8", pulse_x.size());
    end else begin
      for (int i = 0; i < 8; i++) seq[7-i] = pulse_x[i];
      n_checks++;
      if (seq !== 8'b10101101) begin
        n_fail++;
        $display("FAIL diag_sequence got %b (1=X), required 10101101", seq);
      end
      n_checks++;
      if (pulse_cyc[0] != start_cyc + 2 || pulse_cyc[7] != start_cyc + 9) begin
        n_fail++;
        $display("FAIL diag_timing got first=%0d last=%0d, required %0d %0d",
                 pulse_cyc[0] - start_cyc, pulse_cyc[7] - start_cyc, 2, 9);
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 10) begin
      n_fail++;
      $display("FAIL diag_done got count=%0d at +%0d, required 1 at +10", done_cnt, done_cyc - start_cyc);
    end
    n_checks++;
    if (exp_q.size() != 0 || steps_left !== '0) begin
      n_fail++;
      $display("FAIL diag_drain got pending=%0d steps_left=%0d, required 0 0", exp_q.size(), steps_left);
    end
  endtask

  task automatic test_single_axis();
    bit to;
    int xs [2] = '{0, 4};
    int ys [2] = '{4, 0};
    for (int k = 0; k < 2; k++) begin
      start_seg(xs[k], ys[k], 1'b1, 1'b0);
      wait_idle(30, to);
      n_checks++;
      if (to || count_x() != xs[k] || (pulse_x.size() - count_x()) != ys[k] || done_cnt != 1) begin
        n_fail++;
        $display("FAIL axis_%0d got nx=%0d ny=%0d done=%0d timeout=%b, required nx=%0d ny=%0d done=1",
                 k, count_x(), pulse_x.size() - count_x(), done_cnt, to, xs[k], ys[k]);
      end
    end
  endtask

  task automatic test_zero_length();
    bit to;
    start_seg(0, 0, 1'b0, 1'b0);
    wait_idle(20, to);
    n_checks++;
    if (to || pulse_x.size() != 0 || done_cnt != 1 || done_cyc != start_cyc + 2) begin
      n_fail++;
      $display("FAIL zero_len got pulses=%0d done=%0d at +%0d, required 0 pulses, 1 done at +2",
               pulse_x.size(), done_cnt, done_cyc - start_cyc);
    end
  endtask

  task automatic test_abort();
    bit to;
    bit reached = 1'b0;
    start_seg(10, 10, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(posedge pulse_clk);
      if (pulse_cyc.size() >= 5) begin
        reached = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL abort_wait got %0d pulses within 60 cycles, required 5", pulse_cyc.size());
    end
    #1 abort = 1'b1;
    @(posedge pulse_clk);
    #1 abort = 1'b0;
    @(negedge pulse_clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy got %b, required 0", busy);
    end
    repeat (10) @(posedge pulse_clk);
    n_checks++;
    if (pulse_cyc.size() != 5 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_quiet got pulses=%0d done=%0d, required 5 0", pulse_cyc.size(), done_cnt);
    end
    exp_q.delete();
    // Abort wins over start in the same cycle
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge pulse_clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge pulse_clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_priority got busy=%b, required 0", busy);
    end
    start_seg(3, 2, 1'b0, 1'b0);
    wait_idle(30, to);
    n_checks++;
    if (to || count_x() != 3 || pulse_x.size() != 5 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL abort_restart got nx=%0d total=%0d done=%0d, required 3 5 1",
               count_x(), pulse_x.size(), done_cnt);
    end
  endtask

  task automatic test_restart_ignored();
    bit to;
    start_seg(6, 4, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(posedge pulse_clk);
      if (pulse_cyc.size() >= 3) break;
    end
    #1;
    start  = 1'b1;
    xe_abs = W'(1);
    ye_abs = W'(1);
    @(posedge pulse_clk);
    #1 start = 1'b0;
    wait_idle(40, to);
    n_checks++;
    if (to || count_x() != 6 || (pulse_x.size() - count_x()) != 4 || done_cnt != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_ignored got nx=%0d ny=%0d done=%0d pending=%0d, required 6 4 1 0",
               count_x(), pulse_x.size() - count_x(), done_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_midway();
    start_seg(8, 8, 1'b1, 1'b1);
    repeat (5) @(posedge pulse_clk);
    #3 sys_rst_l = 1'b0;
    #1;
    n_checks++;
    if ({x_step, y_step, x_dir, y_dir, busy, done} !== 6'b0 || steps_left !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got flags=%b steps_left=%0d, required 0/0",
               {x_step, y_step, x_dir, y_dir, busy, done}, steps_left);
    end
    exp_q.delete();
    @(posedge pulse_clk);
    #1 sys_rst_l = 1'b1;
    repeat (20) @(posedge pulse_clk);
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard got done=%0d busy=%b, required 0 0", done_cnt, busy);
    end
  endtask

`ifdef LINE_FEED_DIV_EN
  task automatic test_feed_div();
    bit to;
    bit ok;
    feed_div = 16'd3;
    start_seg(2, 2, 1'b0, 1'b0);
    feed_div = 16'd0;
    wait_idle(100, to);
    ok = !to && pulse_cyc.size() == 4 && done_cnt == 1;
    if (ok) begin
      if (pulse_cyc[0] != start_cyc + 2) ok = 1'b0;
      for (int i = 1; i < 4; i++) if (pulse_cyc[i] - pulse_cyc[i-1] != 4) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL feed_div got pulses=%0d done=%0d timeout=%b, required 4 pulses 4 cycles apart from +2",
               pulse_cyc.size(), done_cnt, to);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_diagonal();
    test_single_axis();
    test_zero_length();
    test_abort();
    test_restart_ignored();
    test_reset_midway();
`ifdef LINE_FEED_DIV_EN
    test_feed_div();
`endif
    repeat (3) @(posedge pulse_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
